// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one 16-bit RAM controller between port A (CPU) and port B
//   (video/DMA). Accesses are serialised: each level-sensitive strobe is held
//   for HOLD cycles, then kept low for at least GAP cycles so the controller's
//   edge detector sees a fresh rising edge. Read data is returned with a
//   one-cycle ack. Runs entirely in the clk_sdram domain.
//
// Ports
//   clk_sdram, init_n         clock / async active-low reset
//   a_* / b_*                 requester ports (addr, din, wtbt, we, rd in;
//                             dout, ack out)
//   mem_*                     controller side (addr, din, wtbt, we, rd out;
//                             dout in)
//   busy                      high in WAIT and while an access is in flight
//
// state  | meaning
// -------+---------------------------------------------------------------
// WAIT   | post-reset delay while the controller starts up; no grants
// IDLE   | arbitrate; grant and raise the strobe on the same edge
// HOLD_S | strobe high, controller inputs frozen; ack on the final edge
// GAP_S  | strobes low so the next access produces a rising edge

module sram_arbiter #(
  parameter int HOLD      = 32,
  parameter int GAP       = 3,
  parameter int INIT_WAIT = 10240,
  parameter int AW        = 24
) (
  input  logic          clk_sdram,
  input  logic          init_n,
  input  logic [AW-1:0] a_addr,
  input  logic [15:0]   a_din,
  input  logic [1:0]    a_wtbt,
  input  logic          a_we,
  input  logic          a_rd,
  output logic [15:0]   a_dout,
  output logic          a_ack,
  input  logic [AW-1:0] b_addr,
  input  logic [15:0]   b_din,
  input  logic [1:0]    b_wtbt,
  input  logic          b_we,
  input  logic          b_rd,
  output logic [15:0]   b_dout,
  output logic          b_ack,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_din,
  output logic [1:0]    mem_wtbt,
  output logic          mem_we,
  output logic          mem_rd,
  input  logic [15:0]   mem_dout,
  output logic          busy
);

  localparam int MAX_HG = (HOLD > GAP) ? HOLD : GAP;
  localparam int MAX_C  = (INIT_WAIT > MAX_HG) ? INIT_WAIT : MAX_HG;
  localparam int CW     = $clog2(MAX_C + 1);

  typedef enum logic [1:0] {WAIT, IDLE, HOLD_S, GAP_S} state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic            gnt, gnt_d;            // 0 = A, 1 = B
  logic            last_grant, last_d;    // 0 = A, 1 = B
  logic [AW-1:0]   addr_d;
  logic [15:0]     din_d;
  logic [1:0]      wtbt_d;
  logic            we_d, rd_d;
  logic [15:0]     a_dout_d, b_dout_d;
  logic            a_ack_d, b_ack_d;

  logic req_a, req_b, pick_b, sel_we;

  assign req_a  = a_rd | a_we;
  assign req_b  = b_rd | b_we;
  // On a tie the port that did not win last time goes next.
  assign pick_b = req_b & (~req_a | ~last_grant);
  // A write takes priority over a read if both strobes are raised.
  assign sel_we = pick_b ? b_we : a_we;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk_sdram or negedge init_n) begin
    if (!init_n) begin
      state      <= WAIT;
      cnt        <= CW'(INIT_WAIT);
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      mem_addr   <= '0;
      mem_din    <= '0;
      mem_wtbt   <= '0;
      mem_we     <= 1'b0;
      mem_rd     <= 1'b0;
      a_dout     <= '0;
      b_dout     <= '0;
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      gnt        <= gnt_d;
      last_grant <= last_d;
      mem_addr   <= addr_d;
      mem_din    <= din_d;
      mem_wtbt   <= wtbt_d;
      mem_we     <= we_d;
      mem_rd     <= rd_d;
      a_dout     <= a_dout_d;
      b_dout     <= b_dout_d;
      a_ack      <= a_ack_d;
      b_ack      <= b_ack_d;
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    gnt_d    = gnt;
    last_d   = last_grant;
    addr_d   = mem_addr;
    din_d    = mem_din;
    wtbt_d   = mem_wtbt;
    we_d     = mem_we;
    rd_d     = mem_rd;
    a_dout_d = a_dout;
    b_dout_d = b_dout;
    a_ack_d  = 1'b0;
    b_ack_d  = 1'b0;

    case (state)
      WAIT: begin
        // Leave on the edge where the count reaches zero.
        if (cnt <= CW'(1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end

      IDLE: begin
        if (req_a || req_b) begin
          gnt_d   = pick_b;
          last_d  = pick_b;
          addr_d  = pick_b ? b_addr : a_addr;
          din_d   = pick_b ? b_din  : a_din;
          we_d    = sel_we;
          rd_d    = ~sel_we;
          wtbt_d  = sel_we ? (pick_b ? b_wtbt : a_wtbt) : 2'b11;
          cnt_d   = CW'(HOLD - 1);
          state_d = HOLD_S;
        end
      end

      HOLD_S: begin
        if (cnt == '0) begin
          we_d = 1'b0;
          rd_d = 1'b0;
          if (mem_rd) begin
            if (gnt) b_dout_d = mem_dout;
            else     a_dout_d = mem_dout;
          end
          if (gnt) b_ack_d = 1'b1;
          else     a_ack_d = 1'b1;
          cnt_d   = CW'(GAP - 1);
          state_d = GAP_S;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end

      GAP_S: begin
        if (cnt == '0) state_d = IDLE;
        else           cnt_d   = cnt - CW'(1);
      end

      default: state_d = WAIT;
    endcase
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single 16-bit SDRAM-backed static RAM controller between two requesters: port A (CPU) and port B (video/DMA).
- Serialises accesses, holds each level-sensitive rd/we strobe long enough for the controller's edge-detect and worst-case refresh plus access path, and returns read data with a one-cycle ack.
- Sits between the bus masters and the RAM controller, in the clk_sdram domain.

Parameters:
- HOLD, 32: cycles mem_rd/mem_we stay high per access. Must cover refresh + activate + CAS + precharge.
- GAP, 3: cycles the strobes stay low between accesses, so the controller sees a fresh rising edge (≥2 required).
- INIT_WAIT, 10240: cycles after reset release before the first grant. This covers controller startup.
- AW, 24: address width.

Ports:
- clk_sdram  in  1  clock, same clock as the RAM controller
- init_n  in  1  reset; asynchronous, active-low
- a_addr  in  AW  port A word address
- a_din  in  16  port A write data
- a_wtbt  in  2  port A byte enables (bit1 = high byte)
- a_we  in  1  port A write request (level)
- a_rd  in  1  port A read request (level)
- a_dout  out  16  port A read data
- a_ack  out  1  port A access done (1-cycle pulse)
- b_addr, b_din, b_wtbt, b_we, b_rd, b_dout, b_ack: same as port A, for port B
- mem_addr  out  AW  to controller addr
- mem_din  out  16  to controller din
- mem_wtbt  out  2  to controller wtbt
- mem_we  out  1  to controller we
- mem_rd  out  1  to controller rd
- mem_dout  in  16  from controller dout
- busy  out  1  high while in WAIT or an access is in flight

Behaviour:
- Reset (init_n low, asynchronous):
  - state = WAIT, wait counter = INIT_WAIT, last_grant = B (so A wins the first tie).
  - All outputs 0 except busy = 1.
- States: WAIT, IDLE, HOLD_S, GAP_S.
- WAIT:
  - Decrement the counter each cycle; move to IDLE on the cycle it reaches 0.
  - Requests are not acknowledged. Requesters keep them pending.
- IDLE: a port is requesting if its rd or we is high.
  - If both ports request, grant the port not in last_grant (round-robin). Otherwise grant the single requester.
  - On the grant edge, latch addr, din and wtbt into mem_*, and set the grant id and last_grant.
  - If we is high: mem_we = 1, mem_wtbt = port wtbt. Otherwise: mem_rd = 1, mem_wtbt = 2'b11. If rd and we are both high, the write wins.
  - Go to HOLD_S with the counter at HOLD-1. With no request, stay in IDLE with busy = 0.
- HOLD_S:
  - The strobe stays high and mem_addr, mem_din and mem_wtbt stay stable. Port inputs are not re-sampled.
  - When the counter reaches 0, on that edge:
    - Drop the strobe.
    - For a read, latch mem_dout into the granted port's dout. For a write, leave dout unchanged.
    - Pulse the granted port's ack for exactly one cycle.
  - Then go to GAP_S with the counter at GAP-1.
- GAP_S: strobes stay low. When the counter reaches 0, go to IDLE. Arbitration happens in the next IDLE cycle.
- Timing:
  - The grant edge is T; the strobe is high for cycles T+1 through T+HOLD.
  - ack is high in cycle T+HOLD+1, with dout valid in that same cycle.
  - The next grant is at T+HOLD+GAP+1 at the earliest.
  - With both ports requesting continuously, grants alternate A, B, A, B.
- Requester rules:
  - A requester holds rd/we until it sees ack, then must drop it within 1 cycle or it is granted again.
  - If a request is dropped mid-access, the access still completes and ack still pulses.
- dout of each port holds its last read value until that port's next read completes.
- An asynchronous reset mid-access forces the strobes low immediately and returns to WAIT with a full INIT_WAIT count. No ack is issued.
- The counter is $clog2(max(INIT_WAIT, HOLD, GAP)+1) bits wide. No wrap: each load is followed by a count down to 0.

Test Plan:
Sim uses INIT_WAIT=16, HOLD=32, GAP=3, with a behavioural RAM model that updates mem_dout 20 cycles after the strobe rises.
1. Reset, then a_rd=1 at cycle 5 with a_addr=0x000100 → no mem_rd before cycle 17. Grant when WAIT ends, mem_rd high for exactly 32 cycles, a_ack pulse 1 cycle, a_dout = model[0x100].
2. a_we=1, a_addr=0x000200, a_din=0xBEEF, a_wtbt=2'b01 → mem_we high for 32 cycles, mem_wtbt=01, mem_din=0xBEEF. A later read of 0x200 returns low byte 0xEF with the high byte unchanged.
3. a_rd and b_rd raised in the same cycle and held → grants A, B, A, B, with acks 36 cycles apart and mem_rd low ≥3 cycles between accesses.
4. b_rd=1 and b_we=1 together, b_din=0x1234 → write issued (mem_we=1, mem_rd=0); b_dout unchanged.
5. init_n pulled low in cycle 10 of HOLD_S → mem_rd=0 asynchronously, no ack, busy=1. Re-grant only after 16 cycles of WAIT.
6. a_rd dropped after 2 cycles of HOLD_S → mem_rd stays high the full 32 cycles, a_ack still pulses, and there is no second grant.
